addn_wsign_pipe: RTL and testbench

Parametrised, pipelined signed accumulator for the ANS-PWM datapath: computes sum = c[0] ± c[1] ± … ± c[N-1] over N unsigned W-bit contributions, each with its own sign bit. It is the next generation of the fixed four-channel, 16-bit adder and sits between the noise-shaping contribution generators and the PWM comparator. Over the fixed adder it adds channel/width generality, a registered adder tree with valid tracking, a selectable wrap/saturate output mode, and overflow reporting.

---
 rtl/addn_wsign_pipe_pkg.sv | 23 ++
 rtl/addn_wsign_pipe_if.sv | 25 ++
 rtl/addn_wsign_pipe_addtree.sv | 38 +++
 rtl/addn_wsign_pipe.sv | 120 ++++++++++++
 tb/tb_addn_wsign_pipe.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addn_wsign_pipe_pkg.sv
// Shared definitions for the ANS-PWM signed accumulator: internal width,
// tree sizing helpers and the output-mode encoding.
package anspwm_pkg;

    localparam int W_DEF = 16;
    localparam int N_DEF = 4;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } out_mode_e;

    // Wide enough that N signed W-bit terms can never overflow.
    function automatic int iw(input int w, input int n);
        return w + $clog2(n) + 1;
    endfunction

    // Number of terms still alive after k pairwise tree levels.
    function automatic int terms_at(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

endpackage

// File: rtl/addn_wsign_pipe_if.sv
// Sample/result bus of the signed accumulator.
// in_valid marks one sample per cycle with no backpressure (there is no ready); out_valid marks one result, and sum/ovf mean something only while it is high.
interface addn_wsign_pipe_if #(
    parameter int W = anspwm_pkg::W_DEF,
    parameter int N = anspwm_pkg::N_DEF
);
    logic                 in_valid;
    logic [N-1:0][W-1:0]  c;
    logic [N-1:0]         csign;
    logic                 clr_ovf;
    logic                 out_valid;
    logic [W-1:0]         sum;
    logic                 ovf;
    logic                 ovf_sticky;

    modport master (
        output in_valid, c, csign, clr_ovf,
        input  out_valid, sum, ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, c, csign, clr_ovf,
        output out_valid, sum, ovf, ovf_sticky
    );
endinterface

// File: rtl/addn_wsign_pipe_addtree.sv
// One registered level of the adder tree: M terms in, ceil(M/2) pairwise sums out,
// with the valid bit carried alongside.
module addtree_level #(
    parameter int IW = 19,
    parameter int M  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid,
    input  logic [M-1:0][IW-1:0]      terms,
    output logic                      sums_valid,
    output logic [(M+1)/2-1:0][IW-1:0] sums
);
    localparam int MO = (M + 1) / 2;

    logic [2*MO-1:0][IW-1:0] padded;
    logic [MO-1:0][IW-1:0]   sums_d;

    // An odd leftover term is paired with zero, so it passes through unchanged.
    always_comb begin
        padded        = '0;
        padded[M-1:0] = terms;
        sums_d        = '0;
        for (int j = 0; j < MO; j++) begin
            sums_d[j] = padded[2*j] + padded[2*j+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sums       <= '0;
            sums_valid <= 1'b0;
        end else begin
            sums       <= sums_d;
            sums_valid <= valid;
        end
    end
endmodule

// File: rtl/addn_wsign_pipe.sv
// Pipelined signed accumulator: c[0] +/- c[1] +/- ... +/- c[N-1], with a negate
// stage, a registered pairwise adder tree and a wrap/saturate output stage.
module addn_wsign_pipe
    import anspwm_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int N   = N_DEF,
    parameter int SAT = 0
) (
    input logic              clk,
    input logic              rst_n,
    addn_wsign_pipe_if.slave bus
);
    localparam int             IW    = iw(W, N);
    localparam int             D     = $clog2(N);
    localparam out_mode_e      MODE  = (SAT != 0) ? MODE_SAT : MODE_WRAP;
    localparam logic [IW-1:0]  MAX_V = {{(IW-W){1'b0}}, {W{1'b1}}};

    logic [N-1:0][IW-1:0] terms0_d;
    logic [N-1:0][IW-1:0] terms0;
    logic                 v0;

    // Channel 0 is always added; its sign bit is deliberately ignored.
    always_comb begin
        terms0_d = '0;
        for (int i = 0; i < N; i++) begin
            terms0_d[i] = {{(IW-W){1'b0}}, bus.c[i]};
            if (i != 0 && bus.csign[i]) terms0_d[i] = -terms0_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            terms0 <= '0;
            v0     <= 1'b0;
        end else begin
            terms0 <= terms0_d;
            v0     <= bus.in_valid;
        end
    end

    for (genvar k = 0; k < D; k++) begin : g_lvl
        localparam int MK = terms_at(N, k);
        localparam int MO = terms_at(N, k + 1);

        logic [MK-1:0][IW-1:0] terms;
        logic                  valid;
        logic [MO-1:0][IW-1:0] sums;
        logic                  sums_valid;

        if (k == 0) begin : g_src
            assign terms = terms0;
            assign valid = v0;
        end else begin : g_chain
            assign terms = g_lvl[k-1].sums;
            assign valid = g_lvl[k-1].sums_valid;
        end

        addtree_level #(.IW(IW), .M(MK)) u_level (
            .clk        (clk),
            .rst_n      (rst_n),
            .valid      (valid),
            .terms      (terms),
            .sums_valid (sums_valid),
            .sums       (sums)
        );
    end

    logic [IW-1:0] total;
    logic          total_v;

    if (D == 0) begin : g_flat
        assign total   = terms0[0];
        assign total_v = v0;
    end else begin : g_tree
        assign total   = g_lvl[D-1].sums[0];
        assign total_v = g_lvl[D-1].sums_valid;
    end

    logic          below;
    logic          above;
    logic          ovf_d;
    logic [W-1:0]  sum_d;

    always_comb begin
        below = total[IW-1];
        above = $signed(total) > $signed(MAX_V);
        ovf_d = below | above;
        sum_d = total[W-1:0];
        if (MODE == MODE_SAT) begin
            if (below)      sum_d = '0;
            else if (above) sum_d = '1;
        end
    end

    logic          out_valid_q;
    logic [W-1:0]  sum_q;
    logic          ovf_q;
    logic          sticky_q;

    // A fresh overflow beats a simultaneous clear so no event is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            out_valid_q <= total_v;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            sticky_q    <= (sticky_q & ~bus.clr_ovf) | (total_v & ovf_d);
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.sum        = sum_q;
    assign bus.ovf        = ovf_q;
    assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_addn_wsign_pipe.sv
// Bench for addn_wsign_pipe: five instances (W16/N4 wrap+sat, W8/N5 wrap+sat, W8/N1 wrap)
// share stimulus and are checked every cycle against a cycle-indexed arithmetic model.
module tb_addn_wsign_pipe;
  localparam int R = 1024;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT-side inputs
  logic             v16 = 1'b0;
  logic [3:0][15:0] c16 = '0;
  logic [3:0]       s16 = '0;
  logic             v8  = 1'b0;
  logic [4:0][7:0]  c8  = '0;
  logic [4:0]       s8  = '0;
  logic             clr = 1'b0;

  // staged values applied by tick()
  logic             n_v16 = 1'b0;
  logic [3:0][15:0] n_c16 = '0;
  logic [3:0]       n_s16 = '0;
  logic             n_v8  = 1'b0;
  logic [4:0][7:0]  n_c8  = '0;
  logic [4:0]       n_s8  = '0;
  logic             n_clr = 1'b0;

  addn_wsign_pipe_if #(.W(16), .N(4)) if_a ();
  addn_wsign_pipe_if #(.W(16), .N(4)) if_b ();
  addn_wsign_pipe_if #(.W(8),  .N(5)) if_c ();
  addn_wsign_pipe_if #(.W(8),  .N(5)) if_d ();
  addn_wsign_pipe_if #(.W(8),  .N(1)) if_e ();

  assign if_a.in_valid = v16; assign if_a.c = c16; assign if_a.csign = s16; assign if_a.clr_ovf = clr;
  assign if_b.in_valid = v16; assign if_b.c = c16; assign if_b.csign = s16; assign if_b.clr_ovf = clr;
  assign if_c.in_valid = v8;  assign if_c.c = c8;  assign if_c.csign = s8;  assign if_c.clr_ovf = clr;
  assign if_d.in_valid = v8;  assign if_d.c = c8;  assign if_d.csign = s8;  assign if_d.clr_ovf = clr;
  assign if_e.in_valid = v8;  assign if_e.c = c8[0]; assign if_e.csign = s8[0]; assign if_e.clr_ovf = clr;

  addn_wsign_pipe #(.W(16), .N(4), .SAT(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  addn_wsign_pipe #(.W(16), .N(4), .SAT(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  addn_wsign_pipe #(.W(8),  .N(5), .SAT(0)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  addn_wsign_pipe #(.W(8),  .N(5), .SAT(1)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));
  addn_wsign_pipe #(.W(8),  .N(1), .SAT(0)) u_e (.clk(clk), .rst_n(rst_n), .bus(if_e));

  // scoreboard state: expected result per output cycle, per instance
  bit     exp_v  [5][R];
  longint exp_t  [5][R];
  bit     clr_at [R];
  bit     exp_st [5];
  int     wk   [5] = '{16, 16, 8, 8, 8};
  bit     satk [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0][15:0] c;
    logic [3:0]       s;
    logic [15:0]      e_wrap;
    logic [15:0]      e_sat;
    logic             e_ovf;
  } vec16_t;
  vec16_t vt [7];

  // reference model: plain signed arithmetic on the channel values
  function automatic longint lim_of(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint model_sum(input longint t, input int w, input bit sat);
    longint lim;
    lim = lim_of(w);
    if (!sat) return t & lim;
    if (t < 0) return 0;
    if (t > lim) return lim;
    return t;
  endfunction

  function automatic bit model_ovf(input longint t, input int w);
    return (t < 0) || (t > lim_of(w));
  endfunction

  function automatic longint sum16(input logic [3:0][15:0] c, input logic [3:0] s);
    longint t;
    t = longint'(c[0]);
    for (int i = 1; i < 4; i++) t = s[i] ? t - longint'(c[i]) : t + longint'(c[i]);
    return t;
  endfunction

  function automatic longint sum8(input logic [4:0][7:0] c, input logic [4:0] s);
    longint t;
    t = longint'(c[0]);
    for (int i = 1; i < 5; i++) t = s[i] ? t - longint'(c[i]) : t + longint'(c[i]);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // driver: applies staged inputs just after a clock edge and records expectations
  task automatic tick();
    int i4, i5, i2;
    @(posedge clk); #1;
    v16 = n_v16; c16 = n_c16; s16 = n_s16;
    v8  = n_v8;  c8  = n_c8;  s8  = n_s8;
    clr = n_clr;
    i4 = (cyc + 4) % R; i5 = (cyc + 5) % R; i2 = (cyc + 2) % R;
    if (n_v16) begin
      for (int k = 0; k < 2; k++) begin
        exp_v[k][i4] = 1'b1;
        exp_t[k][i4] = sum16(n_c16, n_s16);
      end
    end
    if (n_v8) begin
      for (int k = 2; k < 4; k++) begin
        exp_v[k][i5] = 1'b1;
        exp_t[k][i5] = sum8(n_c8, n_s8);
      end
      exp_v[4][i2] = 1'b1;
      exp_t[4][i2] = longint'(n_c8[0]);
    end
    clr_at[(cyc + 1) % R] = n_clr;
    n_v16 = 1'b0; n_v8 = 1'b0; n_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mon(input int k, input logic ov, input logic [63:0] sm, input logic of, input logic st);
    int     idx;
    bit     ev;
    longint t;
    idx = cyc % R;
    if (!rst_n) begin
      exp_st[k] = 1'b0;
      chk($sformatf("reset out_valid d%0d", k), 64'(ov), 64'(0));
      chk($sformatf("reset sum d%0d", k), sm, 64'(0));
      chk($sformatf("reset ovf d%0d", k), 64'(of), 64'(0));
      chk($sformatf("reset ovf_sticky d%0d", k), 64'(st), 64'(0));
    end else begin
      ev = exp_v[k][idx];
      t  = exp_t[k][idx];
      chk($sformatf("out_valid d%0d", k), 64'(ov), 64'(ev));
      if (ev) begin
        chk($sformatf("sum d%0d", k), sm, 64'(model_sum(t, wk[k], satk[k])));
        chk($sformatf("ovf d%0d", k), 64'(of), 64'(model_ovf(t, wk[k])));
      end
      if (ev && model_ovf(t, wk[k])) exp_st[k] = 1'b1;
      else if (clr_at[idx])          exp_st[k] = 1'b0;
      chk($sformatf("ovf_sticky d%0d", k), 64'(st), 64'(exp_st[k]));
      exp_v[k][idx] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, if_a.out_valid, 64'(if_a.sum), if_a.ovf, if_a.ovf_sticky);
    mon(1, if_b.out_valid, 64'(if_b.sum), if_b.ovf, if_b.ovf_sticky);
    mon(2, if_c.out_valid, 64'(if_c.sum), if_c.ovf, if_c.ovf_sticky);
    mon(3, if_d.out_valid, 64'(if_d.sum), if_d.ovf, if_d.ovf_sticky);
    mon(4, if_e.out_valid, 64'(if_e.sum), if_e.ovf, if_e.ovf_sticky);
    clr_at[cyc % R] = 1'b0;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    v16 = 1'b0; v8 = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < R; i++) exp_v[k][i] = 1'b0;
    for (int i = 0; i < R; i++) clr_at[i] = 1'b0;
    #1;
    chk("async reset out_valid a", 64'(if_a.out_valid), 64'(0));
    chk("async reset sum a", 64'(if_a.sum), 64'(0));
    chk("async reset ovf_sticky a", 64'(if_a.ovf_sticky), 64'(0));
    chk("async reset out_valid c", 64'(if_c.out_valid), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [18:0] pat;
    logic [18:0] exp_pat;

    vt[0].c = {16'd10, 16'd50, 16'd200, 16'd1000};       vt[0].s = 4'b1100;
    vt[0].e_wrap = 16'd1140;  vt[0].e_sat = 16'd1140;  vt[0].e_ovf = 1'b0;
    vt[1].c = {16'd0, 16'd0, 16'd1, 16'd0};              vt[1].s = 4'b0010;
    vt[1].e_wrap = 16'd65535; vt[1].e_sat = 16'd0;     vt[1].e_ovf = 1'b1;
    vt[2].c = {16'hffff, 16'hffff, 16'hffff, 16'hffff};  vt[2].s = 4'b0000;
    vt[2].e_wrap = 16'd65532; vt[2].e_sat = 16'd65535; vt[2].e_ovf = 1'b1;
    vt[3].c = {16'd0, 16'd0, 16'd0, 16'd5};              vt[3].s = 4'b0001;
    vt[3].e_wrap = 16'd5;     vt[3].e_sat = 16'd5;     vt[3].e_ovf = 1'b0;
    vt[4].c = {16'd0, 16'd0, 16'd0, 16'hffff};           vt[4].s = 4'b0000;
    vt[4].e_wrap = 16'd65535; vt[4].e_sat = 16'd65535; vt[4].e_ovf = 1'b0;
    vt[5].c = {16'd0, 16'd0, 16'd100, 16'd100};          vt[5].s = 4'b0010;
    vt[5].e_wrap = 16'd0;     vt[5].e_sat = 16'd0;     vt[5].e_ovf = 1'b0;
    vt[6].c = {16'hffff, 16'hffff, 16'hffff, 16'd0};     vt[6].s = 4'b1110;
    vt[6].e_wrap = 16'd3;     vt[6].e_sat = 16'd0;     vt[6].e_ovf = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // table-driven vectors, W=16 N=4, result expected exactly 4 cycles later
    for (int i = 0; i < 7; i++) begin
      n_v16 = 1'b1; n_c16 = vt[i].c; n_s16 = vt[i].s;
      tick();
      idle(4);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), 64'(if_a.out_valid), 64'(1));
      chk($sformatf("vec%0d wrap sum", i), 64'(if_a.sum), 64'(vt[i].e_wrap));
      chk($sformatf("vec%0d wrap ovf", i), 64'(if_a.ovf), 64'(vt[i].e_ovf));
      chk($sformatf("vec%0d sat sum", i), 64'(if_b.sum), 64'(vt[i].e_sat));
      chk($sformatf("vec%0d sat ovf", i), 64'(if_b.ovf), 64'(vt[i].e_ovf));
      if (i == 1) chk("underflow sticky", 64'(if_a.ovf_sticky), 64'(1));
    end

    // N=5 (latency 5) and N=1 (latency 2) hand sequence
    n_v8 = 1'b1; n_c8 = {8'd1, 8'd3, 8'd5, 8'd20, 8'd10}; n_s8 = 5'b01010;
    tick();
    idle(2);
    @(negedge clk);
    chk("n1 out_valid at L=2", 64'(if_e.out_valid), 64'(1));
    chk("n1 sum", 64'(if_e.sum), 64'(10));
    idle(2);
    @(negedge clk);
    chk("n5 out_valid before L", 64'(if_c.out_valid), 64'(0));
    idle(1);
    @(negedge clk);
    chk("n5 out_valid at L=5", 64'(if_c.out_valid), 64'(1));
    chk("n5 wrap sum", 64'(if_c.sum), 64'(249));
    chk("n5 sat sum", 64'(if_d.sum), 64'(0));
    chk("n5 ovf", 64'(if_d.ovf), 64'(1));

    // streaming: 8 back-to-back, 2-cycle gap, 1 overflowing sample met by clr_ovf
    idle(6);
    n_clr = 1'b1;
    tick();
    idle(2);
    for (int j = 0; j < 19; j++) begin
      if (j < 8) begin
        n_v16 = 1'b1;
        n_c16[0] = 16'($urandom_range(20000, 40000));
        for (int i = 1; i < 4; i++) n_c16[i] = 16'($urandom_range(0, 5000));
        n_s16 = 4'($urandom);
      end else if (j == 10) begin
        n_v16 = 1'b1;
        n_c16 = {4{16'hffff}};
        n_s16 = 4'b0000;
      end
      if (j == 13) n_clr = 1'b1;
      if (n_v16) exp_q.push_back(16'(model_sum(sum16(n_c16, n_s16), 16, 1'b0)));
      tick();
      @(negedge clk);
      pat[j]     = if_a.out_valid;
      exp_pat[j] = (j >= 4 && j <= 11) || (j == 14);
      if (if_a.out_valid && exp_q.size() > 0)
        chk("stream order", 64'(if_a.sum), 64'(exp_q.pop_front()));
      if (j == 13) chk("sticky clear before ovf", 64'(if_a.ovf_sticky), 64'(0));
      if (j == 14 || j == 15) chk("sticky on clr+ovf", 64'(if_a.ovf_sticky), 64'(1));
    end
    chk("stream valid pattern", 64'(pat), 64'(exp_pat));
    chk("stream queue drained", 64'(exp_q.size()), 64'(0));

    // randomized traffic on both groups
    for (int n = 0; n < 300; n++) begin
      n_v16 = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++)
        n_c16[i] = ($urandom_range(0, 3) == 0) ? 16'hffff : 16'($urandom);
      n_s16 = 4'($urandom);
      n_v8 = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 5; i++)
        n_c8[i] = ($urandom_range(0, 3) == 0) ? 8'(0) : 8'($urandom);
      n_s8 = 5'($urandom);
      n_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle(2);

    // reset with 3 samples in flight
    for (int i = 0; i < 3; i++) begin
      n_v16 = 1'b1; n_c16 = {16'd1, 16'd2, 16'd3, 16'hffff}; n_s16 = 4'b0000;
      n_v8 = 1'b1;  n_c8 = {8'd1, 8'd1, 8'd1, 8'd1, 8'd200}; n_s8 = 5'b00000;
      tick();
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle(1);
      @(negedge clk);
      chk("no out_valid after reset a", 64'(if_a.out_valid), 64'(0));
      chk("no out_valid after reset c", 64'(if_c.out_valid), 64'(0));
    end
    n_v16 = 1'b1; n_c16 = {16'd0, 16'd0, 16'd7, 16'd9}; n_s16 = 4'b0010;
    tick();
    idle(4);
    @(negedge clk);
    chk("post-reset sample out_valid", 64'(if_a.out_valid), 64'(1));
    chk("post-reset sample sum", 64'(if_a.sum), 64'(2));
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
